// File: rtl/key_bounce_gen_if.sv
// Control/status bundle for the key bounce generator. The master drives start
// and observes the emulated key and sequence status.
interface key_bounce_gen_if;
    logic       start;
    logic       key_out;
    logic       busy;
    logic       done;
    logic [7:0] press_cnt;

    modport master (
        output start,
        input  key_out,
        input  busy,
        input  done,
        input  press_cnt
    );

    modport slave (
        input  start,
        output key_out,
        output busy,
        output done,
        output press_cnt
    );
endinterface

// File: rtl/key_bounce_gen.sv
// Emulates one press/release of a mechanical key: LFSR-driven bounce on the
// way down, a stable hold, and LFSR-driven bounce on the way back up.
module key_bounce_gen #(
    parameter logic [19:0] BOUNCE_MAX = 20'd50,
    parameter logic [21:0] HOLD_MAX   = 22'd80,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    key_bounce_gen_if.slave   kb
);

    localparam int          CNT_W       = 22;
    localparam logic [21:0] BOUNCE_LAST = {2'b00, BOUNCE_MAX} - 22'd1;
    localparam logic [21:0] HOLD_LAST   = HOLD_MAX - 22'd1;
    // An all-zero seed would lock the LFSR, so it is replaced at reset.
    localparam logic [15:0] SEED_INIT   = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               lfsr_fb;
    logic               key_q, key_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         press_cnt_q, press_cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 22'd1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (kb.start) begin
                    state_d = PRESS;
                end
            end
            PRESS:   if (cnt_q == BOUNCE_LAST) state_d = HOLD;
            HOLD:    if (cnt_q == HOLD_LAST)   state_d = RELEASE;
            RELEASE: if (cnt_q == BOUNCE_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1; steps only while bouncing.
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = lfsr_q;
        if (state_d == PRESS || state_d == RELEASE) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end

        // Outputs are computed from the next state so they line up with it.
        case (state_d)
            IDLE:    key_d = 1'b1;
            HOLD:    key_d = 1'b0;
            default: key_d = lfsr_d[0];
        endcase
        busy_d      = (state_d != IDLE);
        done_d      = (state_q == RELEASE) && (state_d == IDLE);
        press_cnt_d = press_cnt_q + {7'd0, done_d};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lfsr_q      <= SEED_INIT;
            key_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            key_q       <= key_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign kb.key_out   = key_q;
    assign kb.busy      = busy_q;
    assign kb.done      = done_q;
    assign kb.press_cnt = press_cnt_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen: a short-timing instance (4/10) for the
// sequencing scenarios and a long-bounce zero-seed instance for the LFSR.
module tb_key_bounce_gen;

    logic sys_clk;
    logic sys_rst_n;
    int   checks;
    int   errors;

    key_bounce_gen_if kb1 ();
    key_bounce_gen_if kb2 ();

    key_bounce_gen #(
        .BOUNCE_MAX (20'd4),
        .HOLD_MAX   (22'd10),
        .SEED       (16'hACE1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kb        (kb1)
    );

    key_bounce_gen #(
        .BOUNCE_MAX (20'd300),
        .HOLD_MAX   (22'd5),
        .SEED       (16'h0000)
    ) dut2 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .kb        (kb2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic wait_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        kb1.start = 1'b0;
        kb2.start = 1'b0;
        sys_rst_n = 1'b1;
        #3 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (kb1.key_out !== 1'b1 || kb1.busy !== 1'b0 || kb1.done !== 1'b0 || kb1.press_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: key=%b busy=%b done=%b cnt=%0d, required key=1 busy=0 done=0 cnt=0",
                     kb1.key_out, kb1.busy, kb1.done, kb1.press_cnt);
        end
        checks++;
        if (kb2.key_out !== 1'b1 || kb2.busy !== 1'b0 || kb2.press_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs2: key=%b busy=%b cnt=%0d, required key=1 busy=0 cnt=0",
                     kb2.key_out, kb2.busy, kb2.press_cnt);
        end
        @(negedge sys_clk) sys_rst_n = 1'b1;
        wait_cycle();
        checks++;
        if (kb1.busy !== 1'b0 || kb1.key_out !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b key=%b, required busy=0 key=1", kb1.busy, kb1.key_out);
        end
        $display("test_reset done");
    endtask

    // One start pulse straight after reset: full cycle-by-cycle expectation.
    task automatic test_single();
        logic [15:0] m_lfsr;
        logic        exp_key;
        m_lfsr = 16'hACE1;
        kb1.start = 1'b1;
        wait_cycle();
        kb1.start = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            if (i <= 4 || i >= 15) begin
                m_lfsr  = lfsr_step(m_lfsr);
                exp_key = m_lfsr[0];
            end else begin
                exp_key = 1'b0;
            end
            checks++;
            if (kb1.busy !== 1'b1 || kb1.done !== 1'b0 || kb1.key_out !== exp_key) begin
                errors++;
                $display("FAIL single_cycle%0d: busy=%b done=%b key=%b, required busy=1 done=0 key=%b",
                         i, kb1.busy, kb1.done, kb1.key_out, exp_key);
            end
            wait_cycle();
        end
        checks++;
        if (kb1.busy !== 1'b0 || kb1.done !== 1'b1 || kb1.key_out !== 1'b1 || kb1.press_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_end: busy=%b done=%b key=%b cnt=%0d, required busy=0 done=1 key=1 cnt=1",
                     kb1.busy, kb1.done, kb1.key_out, kb1.press_cnt);
        end
        wait_cycle();
        checks++;
        if (kb1.done !== 1'b0 || kb1.busy !== 1'b0 || kb1.press_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_after: done=%b busy=%b cnt=%0d, required done=0 busy=0 cnt=1",
                     kb1.done, kb1.busy, kb1.press_cnt);
        end
        $display("test_single done: press_cnt=%0d", kb1.press_cnt);
    endtask

    task automatic test_back_to_back();
        logic [7:0] base;
        int         dones;
        int         idles;
        bit         seen;
        base  = kb1.press_cnt;
        dones = 0;
        idles = 0;
        kb1.start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            wait_cycle();
            if (kb1.busy === 1'b0) begin
                idles++;
                checks++;
                if (kb1.done !== 1'b1 || kb1.key_out !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gap_cycle%0d: done=%b key=%b, required done=1 key=1",
                             k, kb1.done, kb1.key_out);
                end
            end
            if (kb1.done === 1'b1) dones++;
        end
        kb1.start = 1'b0;
        checks++;
        if (dones != 3 || idles != 3 || kb1.press_cnt !== base + 8'd3) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d idles=%0d cnt=%0d, required dones=3 idles=3 cnt=%0d",
                     dones, idles, kb1.press_cnt, base + 8'd3);
        end
        // A fourth sequence started at cycle 58; let it finish.
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            wait_cycle();
            if (kb1.done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || kb1.press_cnt !== base + 8'd4) begin
            errors++;
            $display("FAIL b2b_tail: seen_done=%0d cnt=%0d, required seen_done=1 cnt=%0d",
                     seen, kb1.press_cnt, base + 8'd4);
        end
        wait_cycle();
        $display("test_back_to_back done: press_cnt=%0d", kb1.press_cnt);
    endtask

    task automatic test_start_in_hold();
        logic [7:0] base;
        int         len;
        base = kb1.press_cnt;
        len  = 0;
        kb1.start = 1'b1;
        wait_cycle();
        kb1.start = 1'b0;
        for (int k = 1; k < 40 && kb1.busy === 1'b1; k++) begin
            len++;
            kb1.start = (k == 8);
            wait_cycle();
        end
        kb1.start = 1'b0;
        checks++;
        if (len != 18 || kb1.done !== 1'b1 || kb1.press_cnt !== base + 8'd1) begin
            errors++;
            $display("FAIL hold_start: len=%0d done=%b cnt=%0d, required len=18 done=1 cnt=%0d",
                     len, kb1.done, kb1.press_cnt, base + 8'd1);
        end
        wait_cycle();
        checks++;
        if (kb1.busy !== 1'b0 || kb1.press_cnt !== base + 8'd1) begin
            errors++;
            $display("FAIL hold_start_latched: busy=%b cnt=%0d, required busy=0 cnt=%0d",
                     kb1.busy, kb1.press_cnt, base + 8'd1);
        end
        $display("test_start_in_hold done: len=%0d", len);
    endtask

    task automatic test_reset_mid();
        int len;
        kb1.start = 1'b1;
        wait_cycle();
        kb1.start = 1'b0;
        for (int k = 1; k < 7; k++) wait_cycle();
        checks++;
        if (kb1.key_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre_reset_key: key=%b, required 0", kb1.key_out);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (kb1.key_out !== 1'b1 || kb1.busy !== 1'b0 || kb1.done !== 1'b0 || kb1.press_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_async: key=%b busy=%b done=%b cnt=%0d, required key=1 busy=0 done=0 cnt=0",
                     kb1.key_out, kb1.busy, kb1.done, kb1.press_cnt);
        end
        wait_cycle();
        wait_cycle();
        @(negedge sys_clk) sys_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_cycle();
            checks++;
            if (kb1.done !== 1'b0 || kb1.busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_post_reset%0d: done=%b busy=%b, required done=0 busy=0",
                         k, kb1.done, kb1.busy);
            end
        end
        len = 0;
        kb1.start = 1'b1;
        wait_cycle();
        kb1.start = 1'b0;
        for (int k = 0; k < 40 && kb1.busy === 1'b1; k++) begin
            len++;
            wait_cycle();
        end
        checks++;
        if (len != 18 || kb1.done !== 1'b1 || kb1.press_cnt !== 8'd1) begin
            errors++;
            $display("FAIL mid_resume: len=%0d done=%b cnt=%0d, required len=18 done=1 cnt=1",
                     len, kb1.done, kb1.press_cnt);
        end
        wait_cycle();
        $display("test_reset_mid done: len=%0d", len);
    endtask

    task automatic test_seed_zero();
        logic [15:0] m_lfsr;
        logic        prev;
        int          toggles;
        bit          seen;
        m_lfsr  = 16'h0001;
        toggles = 0;
        prev    = 1'b0;
        kb2.start = 1'b1;
        wait_cycle();
        kb2.start = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            m_lfsr = lfsr_step(m_lfsr);
            checks++;
            if (kb2.key_out !== m_lfsr[0] || dut2.lfsr_q === 16'h0000) begin
                errors++;
                $display("FAIL seed0_press%0d: key=%b lfsr=%h, required key=%b lfsr nonzero",
                         i, kb2.key_out, dut2.lfsr_q, m_lfsr[0]);
            end
            if (i > 1 && kb2.key_out !== prev) toggles++;
            prev = kb2.key_out;
            wait_cycle();
        end
        checks++;
        if (toggles < 1) begin
            errors++;
            $display("FAIL seed0_toggles: toggles=%0d, required >=1", toggles);
        end
        seen = 0;
        for (int k = 0; k < 700 && !seen; k++) begin
            if (kb2.done === 1'b1) seen = 1;
            else wait_cycle();
        end
        checks++;
        if (!seen || kb2.press_cnt !== 8'd1 || dut2.lfsr_q === 16'h0000) begin
            errors++;
            $display("FAIL seed0_end: seen_done=%0d cnt=%0d lfsr=%h, required seen_done=1 cnt=1 lfsr nonzero",
                     seen, kb2.press_cnt, dut2.lfsr_q);
        end
        $display("test_seed_zero done: toggles=%0d", toggles);
    endtask

    task automatic test_wrap();
        int dones;
        sys_rst_n = 1'b0;
        #1;
        @(negedge sys_clk) sys_rst_n = 1'b1;
        dones = 0;
        kb1.start = 1'b1;
        for (int k = 0; k < 256 * 19 + 50 && dones < 256; k++) begin
            wait_cycle();
            if (kb1.done === 1'b1) begin
                dones++;
                if (dones == 256) kb1.start = 1'b0;
                checks++;
                if (kb1.press_cnt !== dones[7:0]) begin
                    errors++;
                    $display("FAIL wrap_done%0d: cnt=%0d, required %0d", dones, kb1.press_cnt, dones[7:0]);
                end
            end
        end
        kb1.start = 1'b0;
        checks++;
        if (dones != 256 || kb1.press_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_final: dones=%0d cnt=%0d, required dones=256 cnt=0", dones, kb1.press_cnt);
        end
        wait_cycle();
        checks++;
        if (kb1.busy !== 1'b0 || kb1.done !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle: busy=%b done=%b, required busy=0 done=0", kb1.busy, kb1.done);
        end
        $display("test_wrap done: dones=%0d", dones);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_start_in_hold();
        test_reset_mid();
        test_seed_zero();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
